wb_evict_buffer: RTL and testbench
==================================

// Module: wb_evict_buffer
// PURPOSE
//  FIFO write-back (victim) buffer downstream of the 4-way cache's write-back line select.
//  Accepts a dirty 128-bit evicted line plus its line address, holds it, and drains it to
//  physical memory over the pmem write handshake. The cache refill read then proceeds
//  without waiting for the dirty write to finish.
// PARAMETERS
//  width  128  line data width, bits
//  DEPTH  2    buffer entries; power of 2, >= 2
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      reset, asynchronous, active-high
//  evict_valid    in   1      evicted line presented this cycle
//  evict_addr     in   32     line address; bits [3:0] ignored, stored as 0
//  evict_data     in   width  evicted line from write-back select
//  evict_ready    out  1      entry free; push occurs when evict_valid & evict_ready
//  pmem_write     out  1      write request to physical memory
//  pmem_address   out  32     address of head entry
//  pmem_wdata     out  width  data of head entry
//  pmem_resp      in   1      memory done; one-cycle pulse
//  lookup_addr    in   32     cache miss address to check against buffer
//  conflict       out  1      lookup_addr[31:4] matches any valid entry
//  fwd_hit        out  1      forward valid (WB_EVICT_FWD_EN only, else 0)
//  fwd_data       out  width  forwarded line (WB_EVICT_FWD_EN only, else 0)
//  empty          out  1      count == 0
//  count          out  $clog2(DEPTH)+1  valid entries
// BEHAVIOUR
//  - Reset, async: count=0, all valid bits=0, head=tail=0, FSM=IDLE.
//    pmem_write=0, pmem_address=0, pmem_wdata=0, evict_ready=1, empty=1.
//  - Circular FIFO. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - evict_ready = (count < DEPTH), computed from registered count only.
//    No same-cycle bypass: a full buffer freeing a slot in cycle N accepts from N+1.
//  - Push: writes the entry at wr_ptr, sets its valid bit, count+1. Visible to the FSM next cycle.
//  - FSM states IDLE / WRITE / RETIRE:
//      IDLE:   count != 0 -> WRITE.
//      WRITE:  pmem_write=1; address and data from rd_ptr entry, held stable; pmem_resp -> RETIRE.
//      RETIRE: clears rd_ptr valid, rd_ptr+1, count-1, pmem_write=0;
//              -> WRITE if count-1 != 0, else IDLE.
//  - Minimum latency: push at cycle N -> pmem_write high from N+2 -> entry retired the cycle after pmem_resp.
//  - Push and retire in the same cycle: count unchanged, both pointers advance.
//  - pmem_resp outside WRITE is ignored.
//  - Push while full is dropped with no state change; the bench treats it as a protocol error.
//  - conflict is combinational. It compares [31:4] against every valid entry, including the head being written.
//    The cache must not issue a pmem read for a conflicting line unless fwd_hit=1.
//  - Reset mid-WRITE: pmem_write drops immediately and buffered data is lost. System reset only.
// CONFIGURATION
//  - WB_EVICT_FWD_EN defined:
//      fwd_hit = conflict; fwd_data = matching entry's data.
//      If several entries match, the youngest entry (nearest wr_ptr-1) wins, as a priority select.
//      The cache fills from fwd_data with no pmem read.
//  - WB_EVICT_FWD_EN undefined:
//      fwd_hit=0 and fwd_data=0 constantly; no compare or mux logic is built.
//      The cache stalls on conflict until the entry retires.
// TESTING
//  1. Reset mid-stream: push A, assert rst while pmem_write=1
//     -> pmem_write=0, count=0, empty=1, evict_ready=1 in the same cycle.
//  2. Single push: addr 0x0000_1238, data 128'hDEAD..BEEF at N
//     -> pmem_write=1 at N+2, pmem_address=0x0000_1230; resp at M -> count=0 at M+1, empty=1.
//  3. Fill: DEPTH=2, push A, B back-to-back with resp held off
//     -> evict_ready=0 after second push.
//     -> Resp retires A; ready=1 next cycle; B written next at its own address.
//  4. Push and retire together: count=1 in WRITE, resp and new push in the same cycle
//     -> count stays 1, new entry written after RETIRE.
//  5. Conflict: entries at 0x100 and 0x200, lookup_addr=0x20C -> conflict=1.
//     lookup_addr=0x300 -> conflict=0.
//  6. Forwarding: with WB_EVICT_FWD_EN, push 0x400/dataX, then 0x400/dataY, lookup 0x400
//     -> fwd_hit=1, fwd_data=dataY.
//     Without the macro -> fwd_hit=0, conflict=1.

Source files
------------

// File: rtl/wb_evict_buffer_if.sv
// Handshake bundle for the write-back victim buffer.
// Carries the eviction push port from the cache and the pmem write port.
interface wb_evict_buffer_if #(
    parameter int width = 128
);
    logic             evict_valid;
    logic [31:0]      evict_addr;
    logic [width-1:0] evict_data;
    logic             evict_ready;
    logic             pmem_write;
    logic [31:0]      pmem_address;
    logic [width-1:0] pmem_wdata;
    logic             pmem_resp;

    // master: cache/memory environment, slave: the buffer itself
    modport master (
        output evict_valid, evict_addr, evict_data, pmem_resp,
        input  evict_ready, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  evict_valid, evict_addr, evict_data, pmem_resp,
        output evict_ready, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/wb_evict_buffer.sv
// FIFO victim buffer: holds dirty evicted lines and drains them to pmem one at a time.
// Define WB_EVICT_FWD_EN to forward buffered line data to a conflicting miss lookup.
//
//  state  | meaning
//  IDLE   | buffer empty, no pmem write in flight
//  WRITE  | head entry presented on pmem, waiting for pmem_resp
//  RETIRE | head just retired; one-cycle gap before the next write
module wb_evict_buffer #(
    parameter int width = 128,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_evict_buffer_if.slave         bus,
    input  logic [31:0]              lookup_addr,
    output logic                     conflict,
    output logic                     fwd_hit,
    output logic [width-1:0]         fwd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, RETIRE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [DEPTH-1:0] valid_q;
    logic [27:0]      tag_q  [DEPTH];
    logic [width-1:0] data_q [DEPTH];
    logic             push, retire;
    logic             unused_lsbs;

    // Low nibble of line addresses carries no information.
    assign unused_lsbs = ^{bus.evict_addr[3:0], lookup_addr[3:0]};

    assign bus.evict_ready = (count < CW'(DEPTH));
    assign push            = bus.evict_valid & bus.evict_ready;
    // Retire on the response edge so count reflects it the cycle after pmem_resp.
    assign retire          = (state_q == WRITE) & bus.pmem_resp;
    assign empty           = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= '0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(retire);
        end
    end

    // Payload storage needs no reset; valid_q qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr]  <= bus.evict_addr[31:4];
            data_q[wr_ptr] <= bus.evict_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.pmem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) state_d = WRITE;
            end
            WRITE: begin
                bus.pmem_write = 1'b1;
                if (bus.pmem_resp) state_d = RETIRE;
            end
            RETIRE: begin
                state_d = (count != '0) ? WRITE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pmem_address = bus.pmem_write ? {tag_q[rd_ptr], 4'h0} : 32'h0;
    assign bus.pmem_wdata   = bus.pmem_write ? data_q[rd_ptr] : '0;

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_addr[31:4])) conflict = 1'b1;
        end
    end

`ifdef WB_EVICT_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (valid_q[fwd_idx] && (tag_q[fwd_idx] == lookup_addr[31:4])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_evict_buffer.sv
// Directed self-checking bench for wb_evict_buffer (DEPTH=2).
module tb_wb_evict_buffer;
    localparam int W = 128;
`ifdef WB_EVICT_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   lookup_addr;
    logic          conflict, fwd_hit, empty;
    logic [W-1:0]  fwd_data;
    logic [1:0]    count;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_evict_buffer_if #(.width(W)) bus ();

    wb_evict_buffer #(.width(W), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .lookup_addr (lookup_addr),
        .conflict    (conflict),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .empty       (empty),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          phase;
        logic [31:0] addr;
        logic        exp_conflict;
        logic [W-1:0] data;
    } vec_t;

    vec_t vecs [9];

    localparam logic [W-1:0] D_BEEF = 128'hDEAD_C0DE_0123_4567_89AB_CDEF_F00D_BEEF;
    localparam logic [W-1:0] D_A    = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [W-1:0] D_B    = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [W-1:0] D_C    = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
    localparam logic [W-1:0] D_P    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [W-1:0] D_Q    = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam logic [W-1:0] D_X    = 128'h0123_0123_0123_0123_0123_0123_0123_0123;
    localparam logic [W-1:0] D_Y    = 128'hFEDC_FEDC_FEDC_FEDC_FEDC_FEDC_FEDC_FEDC;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [W-1:0] d);
        bus.evict_valid = 1'b1;
        bus.evict_addr  = a;
        bus.evict_data  = d;
        tick();
        bus.evict_valid = 1'b0;
    endtask

    // Assumes the FSM is in WRITE: respond, then pass the RETIRE cycle.
    task automatic drain_one();
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        tick();
    endtask

    task automatic run_phase(input int ph);
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].phase == ph) begin
                lookup_addr = vecs[i].addr;
                #1;
                check($sformatf("conflict[%0d]", i), W'(conflict), W'(vecs[i].exp_conflict));
                check($sformatf("fwd_hit[%0d]", i), W'(fwd_hit), W'(FWD ? vecs[i].exp_conflict : 1'b0));
                check($sformatf("fwd_data[%0d]", i), fwd_data, FWD ? vecs[i].data : '0);
                tick();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 32'h0000_020C, 1'b1, D_Q};
        vecs[1] = '{1, 32'h0000_0300, 1'b0, '0};
        vecs[2] = '{1, 32'h0000_0100, 1'b1, D_P};
        vecs[3] = '{1, 32'h0000_010F, 1'b1, D_P};
        vecs[4] = '{1, 32'h0000_0110, 1'b0, '0};
        vecs[5] = '{1, 32'h0000_0200, 1'b1, D_Q};
        vecs[6] = '{2, 32'h0000_0400, 1'b1, D_Y};
        vecs[7] = '{2, 32'h0000_040C, 1'b1, D_Y};
        vecs[8] = '{2, 32'h0000_0500, 1'b0, '0};

        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.pmem_resp   = 1'b0;
        lookup_addr     = '0;

        tick();
        tick();
        check("rst_ready",   W'(bus.evict_ready), W'(1));
        check("rst_empty",   W'(empty), W'(1));
        check("rst_count",   W'(count), W'(0));
        check("rst_write",   W'(bus.pmem_write), W'(0));
        check("rst_addr",    W'(bus.pmem_address), W'(0));
        check("rst_wdata",   bus.pmem_wdata, '0);
        check("rst_conflict", W'(conflict), W'(0));
        rst = 1'b0;
        tick();

        // Reset asserted while a write is in flight
        push(32'h0000_5550, D_A);
        tick();
        check("t1_write_before", W'(bus.pmem_write), W'(1));
        rst = 1'b1;
        #1;
        check("t1_write",  W'(bus.pmem_write), W'(0));
        check("t1_count",  W'(count), W'(0));
        check("t1_empty",  W'(empty), W'(1));
        check("t1_ready",  W'(bus.evict_ready), W'(1));
        tick();
        rst = 1'b0;
        tick();

        // pmem_resp outside WRITE is ignored
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        check("idle_resp_count", W'(count), W'(0));
        check("idle_resp_write", W'(bus.pmem_write), W'(0));

        // Single push, minimum latency
        push(32'h0000_1238, D_BEEF);
        check("t2_n1_write", W'(bus.pmem_write), W'(0));
        check("t2_n1_count", W'(count), W'(1));
        tick();
        check("t2_n2_write", W'(bus.pmem_write), W'(1));
        check("t2_addr",     W'(bus.pmem_address), W'(32'h0000_1230));
        check("t2_wdata",    bus.pmem_wdata, D_BEEF);
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        check("t2_count", W'(count), W'(0));
        check("t2_empty", W'(empty), W'(1));
        check("t2_write", W'(bus.pmem_write), W'(0));
        tick();

        // Fill to DEPTH, push while full, then retire
        push(32'h0000_A000, D_A);
        push(32'h0000_B000, D_B);
        check("t3_count", W'(count), W'(2));
        check("t3_ready", W'(bus.evict_ready), W'(0));
        check("t3_addr_a", W'(bus.pmem_address), W'(32'h0000_A000));
        push(32'h0000_C000, D_C);
        check("t3_drop_count", W'(count), W'(2));
        bus.pmem_resp = 1'b1;
        #1;
        check("t3_ready_resp", W'(bus.evict_ready), W'(0));
        tick();
        bus.pmem_resp = 1'b0;
        check("t3_count1", W'(count), W'(1));
        check("t3_ready1", W'(bus.evict_ready), W'(1));
        check("t3_retire_write", W'(bus.pmem_write), W'(0));
        tick();
        check("t3_write_b", W'(bus.pmem_write), W'(1));
        check("t3_addr_b",  W'(bus.pmem_address), W'(32'h0000_B000));
        check("t3_data_b",  bus.pmem_wdata, D_B);
        drain_one();
        check("t3_empty", W'(empty), W'(1));

        // Push and retire in the same cycle
        push(32'h0000_D000, D_A);
        tick();
        check("t4_write_d", W'(bus.pmem_address), W'(32'h0000_D000));
        bus.pmem_resp   = 1'b1;
        bus.evict_valid = 1'b1;
        bus.evict_addr  = 32'h0000_E004;
        bus.evict_data  = D_C;
        #1;
        check("t4_ready", W'(bus.evict_ready), W'(1));
        tick();
        bus.pmem_resp   = 1'b0;
        bus.evict_valid = 1'b0;
        check("t4_count", W'(count), W'(1));
        check("t4_retire_write", W'(bus.pmem_write), W'(0));
        tick();
        check("t4_write_e", W'(bus.pmem_write), W'(1));
        check("t4_addr_e",  W'(bus.pmem_address), W'(32'h0000_E000));
        check("t4_data_e",  bus.pmem_wdata, D_C);
        drain_one();
        check("t4_empty", W'(empty), W'(1));

        // Conflict lookups against two distinct entries
        push(32'h0000_0100, D_P);
        push(32'h0000_0200, D_Q);
        run_phase(1);
        drain_one();
        drain_one();
        check("t5_empty", W'(empty), W'(1));
        lookup_addr = 32'h0000_0200;
        #1;
        check("t5_conflict_after", W'(conflict), W'(0));

        // Same line evicted twice: youngest copy forwarded
        push(32'h0000_0400, D_X);
        push(32'h0000_0400, D_Y);
        run_phase(2);
        drain_one();
        lookup_addr = 32'h0000_0400;
        #1;
        check("t6_conflict_left", W'(conflict), W'(1));
        check("t6_fwd_left", fwd_data, FWD ? D_Y : '0);
        check("t6_head_y", W'(bus.pmem_address), W'(32'h0000_0400));
        check("t6_head_data", bus.pmem_wdata, D_Y);
        drain_one();
        check("t6_empty", W'(empty), W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
